// File: rtl/uart_rx_decoder_if.sv
// Bundle between the UART receiver and its consumers: serial line in,
// latched byte/index, status pulses and LED drive out.
interface uart_rx_decoder_if #(
    parameter int L = 8
);
    logic         i_rxd;
    logic [L-1:0] o_data;
    logic [4:0]   o_code;
    logic         o_valid;
    logic         o_ferr;
    logic         o_busy;
    logic         o_led;

    // master is the receiver itself, slave is whoever drives the line and reads results
    modport master (
        input  i_rxd,
        output o_data, o_code, o_valid, o_ferr, o_busy, o_led
    );

    modport slave (
        output i_rxd,
        input  o_data, o_code, o_valid, o_ferr, o_busy, o_led
    );
endinterface

// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver: oversampled deframing of one byte per frame and decode
// into the transmitter's character index (space=1, 'a'..'z'=2..27, else 0).
module uart_rx_decoder #(
    parameter int D = 234,
    parameter int L = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_rx_decoder_if.master  rx
);
    localparam int H  = D / 2;
    localparam int CW = $clog2(D + 1);
    localparam int BW = (L > 1) ? $clog2(L) : 1;

    localparam logic [CW-1:0] H_C      = CW'(H);
    localparam logic [CW-1:0] D_C      = CW'(D);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(L - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q;
    logic          sync1_q, sync2_q;
    logic          rxs;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] bit_q;
    logic [L-1:0]  shift_q;
    logic [L-1:0]  data_q;
    logic [4:0]    code_q;
    logic [4:0]    code_d;
    logic          valid_q, ferr_q, busy_q, led_q;

    assign rxs = sync2_q;

    // Narrow frames are zero-extended, so their missing upper bits read as 0.
    always_comb begin
        logic [31:0] v;
        v      = 32'(shift_q);
        code_d = 5'd0;
        if (v == 32'h20)
            code_d = 5'd1;
        else if (v >= 32'h61 && v <= 32'h7A)
            code_d = 5'(v - 32'h5F);
    end

    // cnt_q holds the number of cycles elapsed since the last timing reference,
    // so each comparison below lands exactly on a sample instant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            sync1_q <= rx.i_rxd;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q <= START;
                        cnt_q   <= ONE_C;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == H_C) begin
                        cnt_q <= ONE_C;
                        bit_q <= '0;
                        if (rxs) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == D_C) begin
                        cnt_q   <= ONE_C;
                        shift_q <= L'({rxs, shift_q} >> 1);
                        if (bit_q == LAST_BIT)
                            state_q <= STOP;
                        else
                            bit_q <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == D_C) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            data_q  <= shift_q;
                            code_q  <= code_d;
                            led_q   <= (code_d != 5'd0);
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.o_data  = data_q;
    assign rx.o_code  = code_q;
    assign rx.o_valid = valid_q;
    assign rx.o_ferr  = ferr_q;
    assign rx.o_busy  = busy_q;
    assign rx.o_led   = led_q;
endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed bench for uart_rx_decoder at D=16, L=8: clean frames, zero-gap
// frames, framing error with held break, start glitch and mid-frame reset.
module tb_uart_rx_decoder;
    localparam int D = 16;
    localparam int L = 8;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   n_ferr;
    int   fcyc;
    int   vcyc[$];
    int   vcode[$];

    uart_rx_decoder_if #(.L(L)) bus ();

    uart_rx_decoder #(.D(D), .L(L)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .rx    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every pulse with the index of the cycle it occupies.
    initial begin
        n_ferr = 0;
        fcyc   = -1;
    end
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            vcyc.push_back(cyc);
            vcode.push_back(int'(bus.o_code));
        end
        if (bus.o_ferr === 1'b1) begin
            n_ferr <= n_ferr + 1;
            fcyc   <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.i_rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is aligned 1 time unit after a posedge; n0 is that cycle index.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int n0);
        n0 = cyc;
        bus.i_rxd = 1'b0;
        repeat (D) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            bus.i_rxd = b[k];
            repeat (D) @(posedge clk);
            #1;
        end
        bus.i_rxd = stop_bit;
        repeat (D) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, n2, ng;
        logic [7:0] rb;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.i_rxd = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",  32'(bus.o_data),  32'h00);
        check("rst_code",  32'(bus.o_code),  32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ferr",  32'(bus.o_ferr),  32'd0);
        check("rst_busy",  32'(bus.o_busy),  32'd0);
        check("rst_led",   32'(bus.o_led),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // 'a': pulse lands at t0+H+9D+1 = (drive cycle + 2) + 153
        send_frame(8'h61, 1'b1, n0);
        check("a_nvalid", 32'(vcyc.size()), 32'd1);
        check("a_pulse_cyc", 32'(vcyc[0]), 32'(n0 + 155));
        check("a_data", 32'(bus.o_data), 32'h61);
        check("a_code", 32'(bus.o_code), 32'd2);
        check("a_led",  32'(bus.o_led),  32'd1);
        check("a_nferr", 32'(n_ferr), 32'd0);
        idle(10);

        // Zero-gap pair
        send_frame(8'h20, 1'b1, n1);
        send_frame(8'h7A, 1'b1, n2);
        check("b2b_nvalid", 32'(vcyc.size()), 32'd3);
        check("b2b_first_cyc", 32'(vcyc[1]), 32'(n1 + 155));
        check("b2b_spacing", 32'(vcyc[2] - vcyc[1]), 32'd160);
        check("b2b_code1", 32'(vcode[1]), 32'd1);
        check("b2b_code2", 32'(vcode[2]), 32'd27);
        check("b2b_data",  32'(bus.o_data), 32'h7A);
        idle(10);

        send_frame(8'h41, 1'b1, n0);
        check("A_nvalid", 32'(vcyc.size()), 32'd4);
        check("A_data", 32'(bus.o_data), 32'h41);
        check("A_code", 32'(bus.o_code), 32'd0);
        check("A_led",  32'(bus.o_led),  32'd0);
        idle(10);

        // Stop bit low, then line held low as a break
        send_frame(8'h62, 1'b0, n0);
        repeat (100) @(posedge clk);
        #1;
        check("ferr_count", 32'(n_ferr), 32'd1);
        check("ferr_cyc", 32'(fcyc), 32'(n0 + 155));
        check("ferr_nvalid", 32'(vcyc.size()), 32'd4);
        check("ferr_data_kept", 32'(bus.o_data), 32'h41);
        check("ferr_code_kept", 32'(bus.o_code), 32'd0);
        check("ferr_busy_in_break", 32'(bus.o_busy), 32'd1);
        idle(20);
        send_frame(8'h63, 1'b1, n0);
        check("c_nvalid", 32'(vcyc.size()), 32'd5);
        check("c_code", 32'(bus.o_code), 32'd4);
        check("c_data", 32'(bus.o_data), 32'h63);
        check("c_led",  32'(bus.o_led),  32'd1);
        check("c_nferr", 32'(n_ferr), 32'd1);
        idle(10);

        // 5-cycle glitch: t0 = ng+2, busy in ng+3..ng+10, idle again at ng+11
        ng = cyc;
        bus.i_rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.i_rxd = 1'b1;
        @(negedge clk);
        check("glitch_cyc_align", 32'(cyc), 32'(ng + 5));
        check("glitch_busy_high", 32'(bus.o_busy), 32'd1);
        repeat (6) @(negedge clk);
        check("glitch_busy_low", 32'(bus.o_busy), 32'd0);
        @(posedge clk);
        #1;
        idle(20);
        check("glitch_nvalid", 32'(vcyc.size()), 32'd5);
        check("glitch_nferr", 32'(n_ferr), 32'd1);

        // Reset in the middle of data bit 3 of 0x6A
        rb = 8'h6A;
        bus.i_rxd = 1'b0;
        repeat (D) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            bus.i_rxd = rb[k];
            repeat (D) @(posedge clk);
            #1;
        end
        bus.i_rxd = rb[3];
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_data", 32'(bus.o_data), 32'h00);
        check("mid_rst_code", 32'(bus.o_code), 32'd0);
        check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        check("mid_rst_led",  32'(bus.o_led),  32'd0);
        bus.i_rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(200);
        check("post_rst_nvalid", 32'(vcyc.size()), 32'd5);
        check("post_rst_nferr", 32'(n_ferr), 32'd1);
        send_frame(8'h6F, 1'b1, n0);
        check("o_nvalid", 32'(vcyc.size()), 32'd6);
        check("o_pulse_cyc", 32'(vcyc[5]), 32'(n0 + 155));
        check("o_code", 32'(bus.o_code), 32'd16);
        check("o_data", 32'(bus.o_data), 32'h6F);
        check("o_led",  32'(bus.o_led),  32'd1);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_decoder.md
Name: uart_rx_decoder

Overview:
- Receive side of the board's 8N1 UART link, paired with the character-sending transmitter.
- Oversamples the serial input and deframes one byte per frame.
- Decodes the byte into the character index used on the transmit side: space=1, 'a'..'z'=2..27, anything else=0.
- Latches the last received byte and index for the board LED and for downstream logic.

Parameters:
- D, 234, clock cycles per bit period; must be >= 4.
- L, 8, data bits per frame, sent LSB first.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous active-high reset
- i_rxd  input  1  serial line; idle high; asynchronous to i_clk
- o_data  output  L  last correctly framed byte
- o_code  output  5  decoded index of o_data (0..27)
- o_valid  output  1  one-cycle pulse: new o_data/o_code
- o_ferr  output  1  one-cycle pulse: framing error (stop bit sampled low)
- o_busy  output  1  high while a frame is in progress (state != IDLE)
- o_led  output  1  high while o_code != 0

Behaviour:
- Reset (async, active-high) forces:
  - o_data=0, o_code=0, o_valid=0, o_ferr=0, o_busy=0, o_led=0.
  - State IDLE; both synchronizer flops =1; bit and cycle counters =0.
- Reset asserted mid-frame aborts the frame. No o_valid or o_ferr pulse is produced for it.
- Input synchronizer: i_rxd passes through 2 flops to give rxs. All decisions use rxs only.
- Timing reference: t0 = the cycle in which the FSM, in IDLE, sees rxs=0.
- Cycle counter counts clock cycles from t0. H = floor(D/2).
- States and transitions:
  - IDLE: wait for rxs=0, then go to START.
  - START: at t0+H sample rxs.
    - If rxs=1: false start. Return to IDLE with no pulse.
    - If rxs=0: go to DATA.
  - DATA: bit k (k=0..L-1) is sampled at t0+H+(k+1)*D into shift-register position k (LSB first). After bit L-1, go to STOP.
  - STOP: sample rxs at t0+H+(L+1)*D.
    - If rxs=1: cycle after the sample, load o_data, load o_code, pulse o_valid. Go to IDLE.
    - If rxs=0: cycle after the sample, pulse o_ferr; o_data/o_code unchanged. Go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. A line held low never produces a second error or frame.
- Pulse and busy timing:
  - o_valid and o_ferr are mutually exclusive, each exactly 1 cycle wide.
  - o_busy=1 from t0+1 through the pulse cycle inclusive.
- Back-to-back frames: IDLE is re-entered in the pulse cycle. A start edge is accepted from the next cycle, so zero-gap frames are received.
- Decode (combinational from the received byte, registered together with o_data):
  - 0x20 -> 1
  - 0x61..0x7A -> byte-0x5F (i.e. 2..27)
  - any other value -> 0
  - When L<8, the upper bits are treated as 0.
- o_led is registered: equals (o_code != 0), updated in the same cycle as o_code.
- Glitch handling: a low pulse shorter than H cycles is rejected by the START re-check.

Test Plan:
- D=16, L=8: send 0x61 ('a') framed 8N1 -> o_valid pulse 1 cycle at t0+8+9*16+1; o_data=0x61, o_code=2, o_led=1, o_ferr never high.
- Send 0x20, then 0x7A back-to-back with no idle gap -> two o_valid pulses exactly 160 cycles apart; codes 1 then 27; o_data=0x7A.
- Send 0x41 ('A') -> o_valid pulses; o_data=0x41, o_code=0, o_led=0.
- Send 0x62 with stop bit forced low, then hold i_rxd low 100 cycles -> single o_ferr pulse; o_data/o_code keep previous values; no activity until i_rxd returns high; next frame 0x63 decodes to 4.
- 5-cycle low glitch on idle line -> o_busy high briefly, no o_valid/o_ferr, FSM back in IDLE by t0+9.
- Assert i_rst during DATA bit 3 of a frame -> all outputs 0 immediately, no pulse; next clean frame 0x6F after release -> o_code=16.
